sb_lsu: RTL and testbench

- Load/store bus adapter sitting directly downstream of the core's execute/control stage, on the system-bus (sb) side.
- Takes the stage's memory request (re/we, address, byte size, un_sign, write data), runs a valid/ready transaction on the external data bus, and stalls the pipeline while the transaction is outstanding.
- Returns sign- or zero-extended, lane-aligned load data to the register-file write port.

---
 rtl/sb_lsu_pkg.sv | 27 ++
 rtl/sb_lsu_if.sv | 24 ++
 rtl/sb_lsu_align.sv | 43 ++++
 rtl/sb_lsu.sv | 149 ++++++++++++++
 tb/tb_sb_lsu.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sb_lsu_pkg.sv
// Shared encodings for the load/store bus adapter: access sizes, FSM states,
// default widths and the alignment rule used to reject bad requests.
package sb_lsu_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int MEM_ADDR_WIDTH = 32;

    // byte_sel encodings; 2'b11 falls through to word handling everywhere
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RESP = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        if (size == SZ_HALF) return off[0];
        if (size[1])         return off != 2'b00;
        return 1'b0;
    endfunction

endpackage

// File: rtl/sb_lsu_if.sv
// External data-bus channel: request with valid/ready, read data with rvalid.
interface sb_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/sb_lsu_align.sv
// Lane steering for the four byte lanes: store byte-enables and replicated
// write data, plus load extraction with sign or zero extension.
module sb_lsu_align
    import sb_lsu_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic [1:0]        size_i,
    input  logic [1:0]        off_i,
    input  logic              un_sign_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {(DATA_W/8){wdata_i[7:0]}};
                rdata_o = {{(DATA_W-8){shifted[7] & ~un_sign_i}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {(DATA_W/16){wdata_i[15:0]}};
                rdata_o = {{(DATA_W-16){shifted[15] & ~un_sign_i}}, shifted[15:0]};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = shifted;
            end
        endcase
    end
endmodule

// File: rtl/sb_lsu.sv
// Load/store adapter between the execute stage and the system data bus:
// captures one request, runs the bus handshake, stalls the pipe meanwhile.
module sb_lsu
    import sb_lsu_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_WIDTH,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        byte_sel,
    input  logic              un_sign,
    input  logic [DATA_W-1:0] wdata,
    output logic              hold_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              misalign_o,
    output logic              err_o,
    sb_lsu_if.master          bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              un_sign_q;
    logic [DATA_W-1:0] wdata_q;
    logic              is_read_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              capture;
    logic              hold;
    logic              misalign;
    logic              req_valid;
    logic [3:0]        be_al;
    logic [DATA_W-1:0] wdata_al;
    logic [DATA_W-1:0] rdata_ext;

    sb_lsu_align #(.DATA_W(DATA_W)) u_align (
        .size_i    (size_q),
        .off_i     (addr_q[1:0]),
        .un_sign_i (un_sign_q),
        .wdata_i   (wdata_q),
        .rdata_i   (bus.bus_rdata),
        .be_o      (be_al),
        .wdata_o   (wdata_al),
        .rdata_o   (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            un_sign_q <= 1'b0;
            wdata_q   <= '0;
            is_read_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (capture) begin
                addr_q    <= addr;
                size_q    <= byte_sel;
                un_sign_q <= un_sign;
                wdata_q   <= wdata;
                is_read_q <= mem_re;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        capture       = 1'b0;
        hold          = 1'b0;
        misalign      = 1'b0;
        req_valid     = 1'b0;
        rdata_valid_o = 1'b0;
        err_o         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_re || mem_we) begin
                    if (is_misaligned(byte_sel, addr[1:0])) begin
                        misalign = 1'b1;
                    end else begin
                        // Stall in the request cycle itself so the stage freezes now.
                        capture = 1'b1;
                        hold    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                hold      = 1'b1;
                req_valid = 1'b1;
                if (bus.bus_ready) begin
                    cnt_d   = '0;
                    state_d = is_read_q ? ST_RESP : ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                hold = 1'b1;
                if (bus.bus_rvalid) begin
                    rdata_d = rdata_ext;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                rdata_valid_o = is_read_q;
                state_d       = ST_IDLE;
            end
            ST_ERR: begin
                err_o   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // IDLE-cycle outputs follow the live request, so mask them while reset is held.
    assign hold_o        = hold & rst;
    assign misalign_o    = misalign & rst;
    assign rdata_o       = rdata_q;
    assign bus.bus_valid = req_valid;
    assign bus.bus_we    = req_valid & ~is_read_q;
    assign bus.bus_addr  = req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.bus_be    = req_valid ? be_al : 4'b0000;
    assign bus.bus_wdata = req_valid ? wdata_al : '0;

endmodule

// File: tb/tb_sb_lsu.sv
// Randomized self-checking bench for sb_lsu with a lane/extension reference
// model and a responsive bus slave with programmable ready/rvalid delays.
module tb_sb_lsu;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_re, mem_we, un_sign;
    logic [31:0] addr, wdata;
    logic [1:0]  byte_sel;
    logic        hold_o, rdata_valid_o, misalign_o, err_o;
    logic [31:0] rdata_o;

    always #5 clk = ~clk;

    sb_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sb_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_re        (mem_re),
        .mem_we        (mem_we),
        .addr          (addr),
        .byte_sel      (byte_sel),
        .un_sign       (un_sign),
        .wdata         (wdata),
        .hold_o        (hold_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .misalign_o    (misalign_o),
        .err_o         (err_o),
        .bus           (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_rdata;

    int          o_hold, o_valid, o_unstable, o_rpulse, o_err, o_mis;
    bit          o_timeout;
    logic        o_we;
    logic [31:0] o_addr, o_wdata, o_rdata_pulse, o_rdata_end;
    logic [3:0]  o_be;

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
        int n;
        int o;
        logic [3:0] be;
        n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        o  = int'(off);
        be = 4'b0000;
        for (int i = 0; i < 4; i++) if (i >= o && i < o + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b00) return {24'h0, wd[7:0]} * 32'h0101_0101;
        if (sz == 2'b01) return {16'h0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] off,
                                           input bit us, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * int'(off));
        if (sz == 2'b00) begin
            v = v % 256;
            if (!us && v >= 128) v = v - 256;
        end else if (sz == 2'b01) begin
            v = v % 65536;
            if (!us && v >= 32768) v = v - 65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Drives one request and plays the bus slave; records what it observed.
    task automatic run_txn(input bit rd, input logic [31:0] a, input logic [1:0] sz,
                           input bit us, input logic [31:0] wd, input logic [31:0] rdat,
                           input int rdy, input int rv);
        int vcnt;
        int rcnt;
        bit accepted;
        bit done;
        vcnt = 0; rcnt = 0; accepted = 0; done = 0;
        o_hold = 0; o_valid = 0; o_unstable = 0; o_rpulse = 0; o_err = 0; o_mis = 0;
        o_timeout = 0; o_we = 1'b0; o_addr = '0; o_wdata = '0; o_be = '0;
        o_rdata_pulse = '0; o_rdata_end = '0;
        @(posedge clk); #1;
        mem_re = rd; mem_we = !rd; addr = a; byte_sel = sz; un_sign = us; wdata = wd;
        bus.bus_rdata = rdat;
        for (int k = 0; k < 600 && !done; k++) begin
            @(negedge clk);
            if (hold_o)        o_hold++;
            if (misalign_o)    o_mis++;
            if (err_o)         o_err++;
            if (rdata_valid_o) begin o_rpulse++; o_rdata_pulse = rdata_o; end
            if (accepted && hold_o && !bus.bus_valid) begin
                rcnt++;
                bus.bus_rvalid = (rv >= 0) && (rcnt == rv + 1);
            end else begin
                bus.bus_rvalid = 1'b0;
            end
            if (bus.bus_valid) begin
                vcnt++;
                o_valid++;
                if (vcnt == 1) begin
                    o_we = bus.bus_we; o_addr = bus.bus_addr; o_be = bus.bus_be; o_wdata = bus.bus_wdata;
                end else if (o_we !== bus.bus_we || o_addr !== bus.bus_addr ||
                             o_be !== bus.bus_be || o_wdata !== bus.bus_wdata) begin
                    o_unstable++;
                end
                bus.bus_ready = (vcnt == rdy + 1);
                if (vcnt == rdy + 1) accepted = 1;
            end else begin
                bus.bus_ready = 1'b0;
            end
            if (!hold_o) begin
                o_rdata_end = rdata_o;
                done = 1;
            end
        end
        if (!done) o_timeout = 1;
        mem_re = 1'b0; mem_we = 1'b0;
        bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        mem_re = 1'b1; mem_we = 1'b0; addr = 32'h1003; byte_sel = 2'b00; un_sign = 1'b0;
        wdata = 32'h1234_5678;
        bus.bus_ready = 1'b1; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        checks++;
        if ({hold_o, rdata_valid_o, misalign_o, err_o, bus.bus_valid, bus.bus_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {hold_o, rdata_valid_o, misalign_o, err_o, bus.bus_valid, bus.bus_we});
        end
        checks++;
        if (rdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want 00000000", rdata_o);
        end
        checks++;
        if (bus.bus_addr !== 32'h0 || bus.bus_be !== 4'h0 || bus.bus_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h be=%b wdata=%h want zeros",
                     bus.bus_addr, bus.bus_be, bus.bus_wdata);
        end
        mem_re = 1'b0;
        bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        exp_rdata = 32'h0;
    endtask

    task automatic test_byte_load();
        logic [31:0] e;
        e = m_load(2'b00, 2'b11, 1'b0, 32'h80AA_BBCC);
        run_txn(1'b1, 32'h0000_1003, 2'b00, 1'b0, $urandom, 32'h80AA_BBCC, 0, 0);
        checks++;
        if (o_timeout || o_hold !== 3) begin
            errors++; $display("FAIL byte_load_hold: got %0d cycles want 3", o_hold);
        end
        checks++;
        if (o_rpulse !== 1 || o_rdata_pulse !== e || o_rdata_end !== e) begin
            errors++;
            $display("FAIL byte_load_data: got pulses=%0d rdata=%h want 1 pulse rdata=%h",
                     o_rpulse, o_rdata_pulse, e);
        end
        checks++;
        if (o_addr !== 32'h1000 || o_be !== m_be(2'b00, 2'b11) || o_we !== 1'b0) begin
            errors++;
            $display("FAIL byte_load_bus: got addr=%h be=%b we=%b want 00001000 %b 0",
                     o_addr, o_be, o_we, m_be(2'b00, 2'b11));
        end
        exp_rdata = e;
    endtask

    task automatic test_half_load();
        logic [31:0] e;
        e = m_load(2'b01, 2'b10, 1'b1, 32'hF00D_1234);
        run_txn(1'b1, 32'h0000_2002, 2'b01, 1'b1, $urandom, 32'hF00D_1234, 1, 2);
        checks++;
        if (o_timeout || o_rpulse !== 1 || o_rdata_end !== e) begin
            errors++;
            $display("FAIL half_load_data: got pulses=%0d rdata=%h want 1 pulse rdata=%h",
                     o_rpulse, o_rdata_end, e);
        end
        checks++;
        if (o_addr !== 32'h2000 || o_be !== 4'b1100 || o_unstable !== 0) begin
            errors++;
            $display("FAIL half_load_bus: got addr=%h be=%b unstable=%0d want 00002000 1100 0",
                     o_addr, o_be, o_unstable);
        end
        exp_rdata = e;
    endtask

    task automatic test_byte_store();
        run_txn(1'b0, 32'h0000_3001, 2'b00, 1'b0, 32'h0000_00A5, $urandom, 3, 0);
        checks++;
        if (o_be !== 4'b0010 || o_wdata !== m_wdata(2'b00, 32'hA5) || o_we !== 1'b1 ||
            o_unstable !== 0) begin
            errors++;
            $display("FAIL byte_store_bus: got be=%b wdata=%h we=%b unstable=%0d want 0010 %h 1 0",
                     o_be, o_wdata, o_we, o_unstable, m_wdata(2'b00, 32'hA5));
        end
        checks++;
        if (o_timeout || o_valid !== 4 || o_hold !== 5) begin
            errors++;
            $display("FAIL byte_store_timing: got valid=%0d hold=%0d want 4 5", o_valid, o_hold);
        end
        checks++;
        if (o_rpulse !== 0 || o_rdata_end !== exp_rdata) begin
            errors++;
            $display("FAIL byte_store_rdata: got pulses=%0d rdata=%h want 0 %h",
                     o_rpulse, o_rdata_end, exp_rdata);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] ma [4] = '{32'h0000_4002, 32'h0000_0001, 32'h0000_0003, 32'h0000_8007};
        logic [1:0]  ms [4] = '{2'b10, 2'b01, 2'b11, 2'b01};
        bit          mr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            mem_re = mr[i]; mem_we = !mr[i]; addr = ma[i]; byte_sel = ms[i]; un_sign = 1'b0;
            @(negedge clk);
            checks++;
            if (misalign_o !== 1'b1 || hold_o !== 1'b0 || bus.bus_valid !== 1'b0) begin
                errors++;
                $display("FAIL misalign_pulse[%0d]: got mis=%b hold=%b valid=%b want 1 0 0",
                         i, misalign_o, hold_o, bus.bus_valid);
            end
            mem_re = 1'b0; mem_we = 1'b0;
            @(negedge clk);
            checks++;
            if (misalign_o !== 1'b0 || hold_o !== 1'b0 || bus.bus_valid !== 1'b0) begin
                errors++;
                $display("FAIL misalign_after[%0d]: got mis=%b hold=%b valid=%b want 0 0 0",
                         i, misalign_o, hold_o, bus.bus_valid);
            end
        end
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 32'h0000_5000, 2'b10, 1'b0, $urandom, $urandom, 1, -1);
        checks++;
        if (o_timeout || o_hold !== 1 + 2 + TIMEOUT) begin
            errors++;
            $display("FAIL timeout_hold: got %0d cycles want %0d", o_hold, 1 + 2 + TIMEOUT);
        end
        checks++;
        if (o_err !== 1 || o_rpulse !== 0 || o_rdata_end !== exp_rdata) begin
            errors++;
            $display("FAIL timeout_err: got err=%0d pulses=%0d rdata=%h want 1 0 %h",
                     o_err, o_rpulse, o_rdata_end, exp_rdata);
        end
        @(negedge clk);
        checks++;
        if (err_o !== 1'b0 || hold_o !== 1'b0 || bus.bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got err=%b hold=%b valid=%b want 0 0 0",
                     err_o, hold_o, bus.bus_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [31:0] e;
        @(posedge clk); #1;
        mem_re = 1'b1; mem_we = 1'b0; addr = 32'h0000_6004; byte_sel = 2'b10; un_sign = 1'b0;
        bus.bus_ready = 1'b1; bus.bus_rdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        @(posedge clk); #1 bus.bus_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (hold_o !== 1'b1 || bus.bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: got hold=%b valid=%b want 1 0", hold_o, bus.bus_valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({hold_o, rdata_valid_o, misalign_o, err_o, bus.bus_valid, bus.bus_we} !== 6'b0 ||
            rdata_o !== 32'h0 || bus.bus_addr !== 32'h0 || bus.bus_be !== 4'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got ctrl=%b rdata=%h addr=%h be=%b want all zero",
                     {hold_o, rdata_valid_o, misalign_o, err_o, bus.bus_valid, bus.bus_we},
                     rdata_o, bus.bus_addr, bus.bus_be);
        end
        mem_re = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        exp_rdata = 32'h0;
        rd = $urandom;
        e  = m_load(2'b01, 2'b00, 1'b0, rd);
        run_txn(1'b1, 32'h0000_7000, 2'b01, 1'b0, $urandom, rd, 0, 1);
        checks++;
        if (o_timeout || o_hold !== 4 || o_rpulse !== 1 || o_rdata_end !== e) begin
            errors++;
            $display("FAIL midrst_reload: got hold=%0d pulses=%0d rdata=%h want 4 1 %h",
                     o_hold, o_rpulse, o_rdata_end, e);
        end
        exp_rdata = e;
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            bit          rd;
            bit          us;
            logic [1:0]  sz;
            logic [31:0] a, wd, rdat, e;
            int          rdy, rv, eh;
            rd   = bit'($urandom_range(0, 1));
            us   = bit'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            a    = $urandom;
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz[1])       a[1:0] = 2'b00;
            wd   = $urandom;
            rdat = $urandom;
            rdy  = $urandom_range(0, 3);
            rv   = $urandom_range(0, 3);
            eh   = 1 + rdy + 1 + (rd ? rv + 1 : 0);
            e    = rd ? m_load(sz, a[1:0], us, rdat) : exp_rdata;
            run_txn(rd, a, sz, us, wd, rdat, rdy, rv);
            checks++;
            if (o_timeout || o_hold !== eh || o_valid !== rdy + 1) begin
                errors++;
                $display("FAIL rnd_timing[%0d]: got hold=%0d valid=%0d want %0d %0d",
                         n, o_hold, o_valid, eh, rdy + 1);
            end
            checks++;
            if (o_we !== !rd || o_addr !== {a[31:2], 2'b00} || o_be !== m_be(sz, a[1:0]) ||
                o_unstable !== 0) begin
                errors++;
                $display("FAIL rnd_bus[%0d]: got we=%b addr=%h be=%b unstable=%0d want %b %h %b 0",
                         n, o_we, o_addr, o_be, o_unstable, !rd, {a[31:2], 2'b00}, m_be(sz, a[1:0]));
            end
            checks++;
            if (!rd && o_wdata !== m_wdata(sz, wd)) begin
                errors++;
                $display("FAIL rnd_wdata[%0d]: got %h want %h", n, o_wdata, m_wdata(sz, wd));
            end
            checks++;
            if (o_rpulse !== (rd ? 1 : 0) || o_rdata_end !== e || o_err !== 0 || o_mis !== 0) begin
                errors++;
                $display("FAIL rnd_rdata[%0d]: got pulses=%0d rdata=%h err=%0d mis=%0d want %0d %h 0 0",
                         n, o_rpulse, o_rdata_end, o_err, o_mis, rd ? 1 : 0, e);
            end
            exp_rdata = e;
        end
    endtask

    initial begin
        rst = 1'b0;
        mem_re = 1'b0; mem_we = 1'b0; addr = '0; byte_sel = '0; un_sign = 1'b0; wdata = '0;
        bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0;
        exp_rdata = '0;
        test_reset();
        test_byte_load();
        test_half_load();
        test_byte_store();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
